// File: rtl/score_board_pkg.sv
// Shared types and decode helpers for the scoreboard and the instruction buffer.
package score_board_pkg;

    localparam int unsigned OPT_SIZE   = 7;
    localparam int unsigned FUNCT_SIZE = 3;
    localparam int unsigned REG_SIZE   = 5;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned NUM_REGS   = 1 << REG_SIZE;

    localparam logic [OPT_SIZE-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPT_SIZE-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPT_SIZE-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPT_SIZE-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPT_SIZE-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPT_SIZE-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPT_SIZE-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPT_SIZE-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPT_SIZE-1:0] OPC_OPIMM  = 7'b0010011;

    typedef struct packed {
        logic [OPT_SIZE-1:0]   opt;
        logic [FUNCT_SIZE-1:0] funct;
        logic [REG_SIZE-1:0]   rs1;
        logic [REG_SIZE-1:0]   rs2;
        logic [REG_SIZE-1:0]   rd;
        logic [DATA_WIDTH-1:0] imm;
    } instr_t;

    typedef struct packed {
        logic uses_rs1;
        logic uses_rs2;
        logic writes_rd;
    } reg_use_t;

    function automatic logic is_ls_op(input logic [OPT_SIZE-1:0] opt);
        return (opt == OPC_LOAD) || (opt == OPC_STORE);
    endfunction

    // x0 is folded in here so a write to x0 never looks like a register write.
    function automatic reg_use_t decode_use(input logic [OPT_SIZE-1:0] opt,
                                            input logic [REG_SIZE-1:0] rd);
        reg_use_t u;
        u.uses_rs1  = (opt != OPC_LUI) && (opt != OPC_AUIPC) && (opt != OPC_JAL);
        u.uses_rs2  = (opt == OPC_BRANCH) || (opt == OPC_STORE) || (opt == OPC_OP);
        u.writes_rd = (opt != OPC_STORE) && (opt != OPC_BRANCH) && (rd != '0);
        return u;
    endfunction

endpackage

// File: rtl/sb_station.sv
// Single-entry reservation holder: instruction fields plus decoded register usage.
module sb_station
    import score_board_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     clear,
    input  instr_t   ins_in,
    output logic     busy,
    output instr_t   ins,
    output reg_use_t use_q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy  <= 1'b0;
            ins   <= '0;
            use_q <= '0;
        end else if (clear) begin
            busy <= 1'b0;
        end else if (load) begin
            busy  <= 1'b1;
            ins   <= ins_in;
            use_q <= decode_use(ins_in.opt, ins_in.rd);
        end
    end

endmodule

// File: rtl/score_board.sv
// In-order scoreboard: one ALU and one LS station, pending-write table, age-ordered dispatch.
module score_board
    import score_board_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  ib_valid,
    input  logic [OPT_SIZE-1:0]   ib_opt,
    input  logic [FUNCT_SIZE-1:0] ib_funct,
    input  logic [REG_SIZE-1:0]   ib_rs1,
    input  logic [REG_SIZE-1:0]   ib_rs2,
    input  logic [REG_SIZE-1:0]   ib_rd,
    input  logic [DATA_WIDTH-1:0] ib_imm,
    output logic                  ib_vacant_ALU,
    output logic                  ib_vacant_LS,
    input  logic                  alu_ready,
    output logic                  alu_valid,
    output logic [OPT_SIZE-1:0]   alu_opt,
    output logic [FUNCT_SIZE-1:0] alu_funct,
    output logic [REG_SIZE-1:0]   alu_rs1,
    output logic [REG_SIZE-1:0]   alu_rs2,
    output logic [REG_SIZE-1:0]   alu_rd,
    output logic [DATA_WIDTH-1:0] alu_imm,
    input  logic                  ls_ready,
    output logic                  ls_valid,
    output logic [OPT_SIZE-1:0]   ls_opt,
    output logic [FUNCT_SIZE-1:0] ls_funct,
    output logic [REG_SIZE-1:0]   ls_rs1,
    output logic [REG_SIZE-1:0]   ls_rs2,
    output logic [REG_SIZE-1:0]   ls_rd,
    output logic [DATA_WIDTH-1:0] ls_imm,
    input  logic                  wb_valid,
    input  logic [REG_SIZE-1:0]   wb_rd,
    output logic [NUM_REGS-1:0]   pending
);

    instr_t               ib_ins;
    instr_t               alu_ins, ls_ins;
    reg_use_t             alu_use, ls_use;
    logic                 alu_busy, ls_busy;
    logic                 acc_alu, acc_ls;
    logic                 alu_busy_n, ls_busy_n;
    logic                 older_ls;
    logic                 older_ls_n;
    logic [NUM_REGS-1:0]  wb_mask;
    logic [NUM_REGS-1:0]  pend_eff;
    logic [NUM_REGS-1:0]  pending_n;

    function automatic logic regs_blocked(input logic [NUM_REGS-1:0] pend,
                                          input instr_t i, input reg_use_t u);
        return (u.uses_rs1 && (i.rs1 != '0) && pend[i.rs1]) ||
               (u.uses_rs2 && (i.rs2 != '0) && pend[i.rs2]) ||
               (u.writes_rd && pend[i.rd]);
    endfunction

    // RAW/WAW on the older's rd, or WAR where the younger overwrites an older source.
    function automatic logic order_conflict(input instr_t o, input reg_use_t ou,
                                            input instr_t y, input reg_use_t yu);
        logic raw_waw, war;
        raw_waw = ou.writes_rd && ((yu.uses_rs1 && (y.rs1 == o.rd)) ||
                                   (yu.uses_rs2 && (y.rs2 == o.rd)) ||
                                   (yu.writes_rd && (y.rd == o.rd)));
        war     = yu.writes_rd && ((ou.uses_rs1 && (o.rs1 == y.rd)) ||
                                   (ou.uses_rs2 && (o.rs2 == y.rd)));
        return raw_waw || war;
    endfunction

    assign ib_ins = '{opt: ib_opt, funct: ib_funct, rs1: ib_rs1, rs2: ib_rs2,
                      rd: ib_rd, imm: ib_imm};

    assign acc_alu = ib_valid && !flush && !is_ls_op(ib_opt) && !alu_busy;
    assign acc_ls  = ib_valid && !flush &&  is_ls_op(ib_opt) && !ls_busy;

    sb_station u_alu_station (
        .clk    (clk),
        .rst    (rst),
        .load   (acc_alu),
        .clear  (alu_valid || flush),
        .ins_in (ib_ins),
        .busy   (alu_busy),
        .ins    (alu_ins),
        .use_q  (alu_use)
    );

    sb_station u_ls_station (
        .clk    (clk),
        .rst    (rst),
        .load   (acc_ls),
        .clear  (ls_valid || flush),
        .ins_in (ib_ins),
        .busy   (ls_busy),
        .ins    (ls_ins),
        .use_q  (ls_use)
    );

    // A writeback in the same cycle counts as already cleared.
    always_comb begin
        wb_mask = '0;
        if (wb_valid && (wb_rd != '0)) begin
            wb_mask = NUM_REGS'(1) << wb_rd;
        end
        pend_eff = pending & ~wb_mask;
    end

    always_comb begin
        alu_valid = 1'b0;
        ls_valid  = 1'b0;
        if (!flush) begin
            alu_valid = alu_busy && alu_ready && !regs_blocked(pend_eff, alu_ins, alu_use) &&
                        !(ls_busy && older_ls && order_conflict(ls_ins, ls_use, alu_ins, alu_use));
            ls_valid  = ls_busy && ls_ready && !regs_blocked(pend_eff, ls_ins, ls_use) &&
                        !(alu_busy && !older_ls && order_conflict(alu_ins, alu_use, ls_ins, ls_use));
        end
    end

    // Age tracking: a lone station is older; a fresh accept next to a busy one is younger.
    always_comb begin
        alu_busy_n = acc_alu || (alu_busy && !(alu_valid || flush));
        ls_busy_n  = acc_ls  || (ls_busy  && !(ls_valid  || flush));
        older_ls_n = older_ls;
        if (ls_busy_n && !alu_busy_n) begin
            older_ls_n = 1'b1;
        end else if (alu_busy_n && !ls_busy_n) begin
            older_ls_n = 1'b0;
        end else if (alu_busy_n && ls_busy_n) begin
            if (acc_alu) begin
                older_ls_n = 1'b1;
            end else if (acc_ls) begin
                older_ls_n = 1'b0;
            end
        end else begin
            older_ls_n = 1'b0;
        end
    end

    // Clear on writeback first, then set dispatched destinations so a set wins.
    always_comb begin
        pending_n = pending & ~wb_mask;
        if (alu_valid && alu_use.writes_rd) begin
            pending_n[alu_ins.rd] = 1'b1;
        end
        if (ls_valid && ls_use.writes_rd) begin
            pending_n[ls_ins.rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending  <= '0;
            older_ls <= 1'b0;
        end else begin
            pending  <= pending_n;
            older_ls <= older_ls_n;
        end
    end

    assign ib_vacant_ALU = !alu_busy;
    assign ib_vacant_LS  = !ls_busy;

    assign alu_opt   = alu_ins.opt;
    assign alu_funct = alu_ins.funct;
    assign alu_rs1   = alu_ins.rs1;
    assign alu_rs2   = alu_ins.rs2;
    assign alu_rd    = alu_ins.rd;
    assign alu_imm   = alu_ins.imm;

    assign ls_opt    = ls_ins.opt;
    assign ls_funct  = ls_ins.funct;
    assign ls_rs1    = ls_ins.rs1;
    assign ls_rs2    = ls_ins.rs2;
    assign ls_rd     = ls_ins.rd;
    assign ls_imm    = ls_ins.imm;

endmodule

// File: tb/tb_score_board.sv
// Directed table-driven bench for score_board plus a hand-written mid-run reset sequence.
module tb_score_board;
    import score_board_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        ib_valid = 1'b0;
    instr_t      ib = '0;
    logic        alu_ready = 1'b0;
    logic        ls_ready = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;

    logic        ib_vacant_ALU, ib_vacant_LS;
    logic        alu_valid, ls_valid;
    logic [6:0]  alu_opt, ls_opt;
    logic [2:0]  alu_funct, ls_funct;
    logic [4:0]  alu_rs1, alu_rs2, alu_rd, ls_rs1, ls_rs2, ls_rd;
    logic [31:0] alu_imm, ls_imm;
    logic [31:0] pending;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    score_board dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ib_valid(ib_valid), .ib_opt(ib.opt), .ib_funct(ib.funct),
        .ib_rs1(ib.rs1), .ib_rs2(ib.rs2), .ib_rd(ib.rd), .ib_imm(ib.imm),
        .ib_vacant_ALU(ib_vacant_ALU), .ib_vacant_LS(ib_vacant_LS),
        .alu_ready(alu_ready), .alu_valid(alu_valid), .alu_opt(alu_opt),
        .alu_funct(alu_funct), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_rd(alu_rd), .alu_imm(alu_imm),
        .ls_ready(ls_ready), .ls_valid(ls_valid), .ls_opt(ls_opt),
        .ls_funct(ls_funct), .ls_rs1(ls_rs1), .ls_rs2(ls_rs2),
        .ls_rd(ls_rd), .ls_imm(ls_imm),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .pending(pending)
    );

    typedef struct {
        logic        fl;
        logic        iv;
        instr_t      ins;
        logic        ar;
        logic        lr;
        logic        wv;
        logic [4:0]  wr;
        logic        e_av;
        logic [4:0]  e_ard;
        logic        e_lv;
        logic [4:0]  e_lrd;
        logic        e_vac_a;
        logic        e_vac_l;
        logic [31:0] e_pend;
    } vec_t;

    vec_t vq[$];

    function automatic instr_t mk(input logic [6:0] opt, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [4:0] rd,
                                  input logic [31:0] imm);
        instr_t i;
        i.opt = opt; i.funct = 3'b000; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.imm = imm;
        return i;
    endfunction

    task automatic add(input logic fl, input logic iv, input instr_t ins,
                       input logic ar, input logic lr, input logic wv, input logic [4:0] wr,
                       input logic eav, input logic [4:0] eard, input logic elv,
                       input logic [4:0] elrd, input logic eva, input logic evl,
                       input logic [31:0] ep);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ins = ins; v.ar = ar; v.lr = lr; v.wv = wv; v.wr = wr;
        v.e_av = eav; v.e_ard = eard; v.e_lv = elv; v.e_lrd = elrd;
        v.e_vac_a = eva; v.e_vac_l = evl; v.e_pend = ep;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    endtask

    task automatic drive(input logic fl, input logic iv, input instr_t ins, input logic ar,
                         input logic lr, input logic wv, input logic [4:0] wr);
        flush = fl; ib_valid = iv; ib = ins; alu_ready = ar; ls_ready = lr;
        wb_valid = wv; wb_rd = wr;
    endtask

    initial begin
        instr_t nop, addi5_1, addi5_2, add6, lw7, add8a, add8b, sw9, addi9;
        instr_t lw10, add11, addi12, addi15, lw13, add14;
        nop     = '0;
        addi5_1 = mk(OPC_OPIMM, 5'd0, 5'd0, 5'd5, 32'd1);
        addi5_2 = mk(OPC_OPIMM, 5'd0, 5'd0, 5'd5, 32'd2);
        add6    = mk(OPC_OP,    5'd5, 5'd5, 5'd6, 32'd0);
        lw7     = mk(OPC_LOAD,  5'd1, 5'd0, 5'd7, 32'd0);
        add8a   = mk(OPC_OP,    5'd7, 5'd2, 5'd8, 32'd0);
        add8b   = mk(OPC_OP,    5'd3, 5'd2, 5'd8, 32'd0);
        sw9     = mk(OPC_STORE, 5'd2, 5'd9, 5'd0, 32'd0);
        addi9   = mk(OPC_OPIMM, 5'd0, 5'd0, 5'd9, 32'd3);
        lw10    = mk(OPC_LOAD,  5'd1, 5'd0, 5'd10, 32'd4);
        add11   = mk(OPC_OP,    5'd1, 5'd2, 5'd11, 32'd0);
        addi12  = mk(OPC_OPIMM, 5'd0, 5'd0, 5'd12, 32'd7);
        addi15  = mk(OPC_OPIMM, 5'd0, 5'd0, 5'd15, 32'd9);
        lw13    = mk(OPC_LOAD,  5'd1, 5'd0, 5'd13, 32'd0);
        add14   = mk(OPC_OP,    5'd1, 5'd2, 5'd14, 32'd0);

        //  fl iv ins      ar lr wv wr   | av ard lv lrd vA vL pend
        add(0, 0, nop,     0, 0, 0, 0,     0, 0, 0, 0, 1, 1, 32'h0);
        add(0, 1, addi5_1, 1, 0, 0, 0,     0, 0, 0, 0, 1, 1, 32'h0);
        add(0, 0, nop,     1, 0, 0, 0,     1, 5, 0, 0, 0, 1, 32'h0);
        add(0, 1, add6,    1, 0, 0, 0,     0, 0, 0, 0, 1, 1, 32'h20);
        add(0, 0, nop,     1, 0, 0, 0,     0, 0, 0, 0, 0, 1, 32'h20);
        add(0, 0, nop,     1, 0, 0, 0,     0, 0, 0, 0, 0, 1, 32'h20);
        add(0, 0, nop,     1, 0, 1, 5,     1, 6, 0, 0, 0, 1, 32'h20);
        add(0, 0, nop,     1, 0, 1, 6,     0, 0, 0, 0, 1, 1, 32'h40);
        add(0, 1, lw7,     0, 0, 0, 0,     0, 0, 0, 0, 1, 1, 32'h0);
        add(0, 1, add8a,   1, 0, 0, 0,     0, 0, 0, 0, 1, 0, 32'h0);
        add(0, 0, nop,     1, 0, 0, 0,     0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, nop,     1, 1, 0, 0,     0, 0, 1, 7, 0, 0, 32'h0);
        add(0, 0, nop,     1, 0, 0, 0,     0, 0, 0, 0, 0, 1, 32'h80);
        add(0, 0, nop,     1, 0, 1, 7,     1, 8, 0, 0, 0, 1, 32'h80);
        add(0, 0, nop,     0, 0, 1, 8,     0, 0, 0, 0, 1, 1, 32'h100);
        add(0, 1, lw7,     0, 0, 0, 0,     0, 0, 0, 0, 1, 1, 32'h0);
        add(0, 1, add8b,   0, 0, 0, 0,     0, 0, 0, 0, 1, 0, 32'h0);
        add(0, 0, nop,     1, 0, 0, 0,     1, 8, 0, 0, 0, 0, 32'h0);
        add(0, 0, nop,     0, 1, 0, 0,     0, 0, 1, 7, 1, 0, 32'h100);
        add(0, 0, nop,     0, 0, 1, 7,     0, 0, 0, 0, 1, 1, 32'h180);
        add(0, 0, nop,     0, 0, 1, 8,     0, 0, 0, 0, 1, 1, 32'h100);
        add(0, 1, sw9,     0, 0, 0, 0,     0, 0, 0, 0, 1, 1, 32'h0);
        add(0, 1, addi9,   1, 0, 0, 0,     0, 0, 0, 0, 1, 0, 32'h0);
        add(0, 0, nop,     1, 0, 0, 0,     0, 0, 0, 0, 0, 0, 32'h0);
        add(0, 0, nop,     1, 1, 0, 0,     0, 0, 1, 0, 0, 0, 32'h0);
        add(0, 0, nop,     1, 0, 0, 0,     1, 9, 0, 0, 0, 1, 32'h0);
        add(0, 0, nop,     0, 0, 1, 9,     0, 0, 0, 0, 1, 1, 32'h200);
        add(0, 1, addi5_1, 1, 0, 0, 0,     0, 0, 0, 0, 1, 1, 32'h0);
        add(0, 0, nop,     1, 0, 0, 0,     1, 5, 0, 0, 0, 1, 32'h0);
        add(0, 1, addi5_2, 1, 0, 0, 0,     0, 0, 0, 0, 1, 1, 32'h20);
        add(0, 0, nop,     1, 0, 0, 0,     0, 0, 0, 0, 0, 1, 32'h20);
        add(0, 0, nop,     1, 0, 1, 5,     1, 5, 0, 0, 0, 1, 32'h20);
        add(0, 0, nop,     0, 0, 0, 0,     0, 0, 0, 0, 1, 1, 32'h20);
        add(0, 1, lw10,    0, 0, 0, 0,     0, 0, 0, 0, 1, 1, 32'h20);
        add(0, 1, add11,   0, 0, 0, 0,     0, 0, 0, 0, 1, 0, 32'h20);
        add(1, 0, nop,     1, 1, 0, 0,     0, 0, 0, 0, 0, 0, 32'h20);
        add(0, 0, nop,     1, 1, 0, 0,     0, 0, 0, 0, 1, 1, 32'h20);
        add(1, 1, addi12,  1, 0, 0, 0,     0, 0, 0, 0, 1, 1, 32'h20);
        add(0, 0, nop,     1, 1, 0, 0,     0, 0, 0, 0, 1, 1, 32'h20);
        add(0, 0, nop,     0, 0, 1, 5,     0, 0, 0, 0, 1, 1, 32'h20);
        add(0, 0, nop,     0, 0, 1, 0,     0, 0, 0, 0, 1, 1, 32'h0);
        add(0, 0, nop,     0, 0, 0, 0,     0, 0, 0, 0, 1, 1, 32'h0);

        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].fl, vq[i].iv, vq[i].ins, vq[i].ar, vq[i].lr, vq[i].wv, vq[i].wr);
            #1;
            chk($sformatf("row%0d alu_valid", i), 32'(alu_valid), 32'(vq[i].e_av));
            chk($sformatf("row%0d ls_valid", i), 32'(ls_valid), 32'(vq[i].e_lv));
            chk($sformatf("row%0d vacant_alu", i), 32'(ib_vacant_ALU), 32'(vq[i].e_vac_a));
            chk($sformatf("row%0d vacant_ls", i), 32'(ib_vacant_LS), 32'(vq[i].e_vac_l));
            chk($sformatf("row%0d pending", i), pending, vq[i].e_pend);
            if (vq[i].e_av) chk($sformatf("row%0d alu_rd", i), 32'(alu_rd), 32'(vq[i].e_ard));
            if (vq[i].e_lv) chk($sformatf("row%0d ls_rd", i), 32'(ls_rd), 32'(vq[i].e_lrd));
        end

        // Mid-run reset with both stations occupied and a pending bit set.
        @(negedge clk); drive(0, 1, addi15, 1, 0, 0, 0);
        @(negedge clk); drive(0, 0, nop,    1, 0, 0, 0);
        #1 chk("pre_rst alu_valid", 32'(alu_valid), 32'd1);
        @(negedge clk); drive(0, 1, lw13,   0, 0, 0, 0);
        @(negedge clk); drive(0, 1, add14,  0, 0, 0, 0);
        @(negedge clk); drive(0, 0, nop,    0, 0, 0, 0);
        #1;
        chk("pre_rst vacant_alu", 32'(ib_vacant_ALU), 32'd0);
        chk("pre_rst vacant_ls", 32'(ib_vacant_LS), 32'd0);
        chk("pre_rst pending", pending, 32'h8000);
        alu_ready = 1'b1; ls_ready = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst vacant_alu", 32'(ib_vacant_ALU), 32'd1);
        chk("rst vacant_ls", 32'(ib_vacant_LS), 32'd1);
        chk("rst pending", pending, 32'h0);
        chk("rst alu_valid", 32'(alu_valid), 32'd0);
        chk("rst ls_valid", 32'(ls_valid), 32'd0);
        chk("rst alu_rd", 32'(alu_rd), 32'd0);
        chk("rst ls_imm", ls_imm, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd15;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("post_rst%0d alu_valid", c), 32'(alu_valid), 32'd0);
            chk($sformatf("post_rst%0d ls_valid", c), 32'(ls_valid), 32'd0);
            chk($sformatf("post_rst%0d pending", c), pending, 32'h0);
            @(negedge clk);
            wb_valid = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/score_board.md
Name: score_board

Overview:
- In-order-issue scoreboard between i_buffer and the two execution units (ALU, load/store).
- Holds one instruction per unit class in a station and tracks pending destination registers.
- Dispatches an instruction to its unit once its operands are free of hazards and the unit is ready.
- Drives the sb_vacant_ALU / sb_vacant_LS back-pressure signals consumed by i_buffer.

Parameters:
OPT_SIZE, 7, opcode width
FUNCT_SIZE, 3, funct3 width
REG_SIZE, 5, register index width (32 architectural regs)
DATA_WIDTH, 32, immediate width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
flush  in  1  discard both stations (pending table kept)
ib_valid  in  1  instruction present from i_buffer
ib_opt/ib_funct/ib_rs1/ib_rs2/ib_rd/ib_imm  in  7/3/5/5/5/32  instruction fields
ib_vacant_ALU  out  1  ALU station empty
ib_vacant_LS  out  1  LS station empty
alu_ready  in  1  ALU can take an op this cycle
alu_valid  out  1  dispatch to ALU
alu_opt/alu_funct/alu_rs1/alu_rs2/alu_rd/alu_imm  out  7/3/5/5/5/32  dispatched fields
ls_ready, ls_valid, ls_opt..ls_imm  same as ALU group, for the load/store unit
wb_valid  in  1  a unit writes back this cycle
wb_rd  in  5  writeback register
pending  out  32  pending-write mask (debug)

Behaviour:
- Reset (rst=0, async): both stations empty; age bit cleared; pending=0; alu_valid=ls_valid=0; all field outputs 0; both vacant outputs=1.
- Classification: opt 0000011 (LOAD) or 0100011 (STORE) -> LS; every other opcode -> ALU.
- Register use:
  - writes_rd: all opcodes except STORE and BRANCH (1100011), and only when rd!=0.
  - uses_rs1: all opcodes except LUI (0110111), AUIPC (0010111), JAL (1101111).
  - uses_rs2: BRANCH, STORE, OP (0110011) only.
  - x0 never pending and never a hazard.
- Vacant outputs: vacant_X = ~station_X_busy, taken straight from the station register.
  - A station freed by dispatch becomes vacant the next cycle, so there is one bubble per refill.
- Accept: ib_valid with the class's station empty -> latch the fields at the clock edge.
  - ib_valid with the class's station occupied is a protocol violation; the instruction is ignored.
- Age: one bit records which station is older.
  - An instruction accepted while the other station is busy is the younger.
  - If only one station is busy, it is the older.
- Eligibility of a station (combinational), all of the following:
  - busy;
  - unit ready;
  - each used rs and written rd not pending, where a same-cycle wb_valid/wb_rd counts as cleared (bypass);
  - if younger: no conflict with a busy older station:
    - older writes rd equal to younger rs1/rs2/rd (where used/written);
    - younger writes rd equal to older rs1/rs2 (where used).
- Dispatch:
  - Both stations may dispatch in the same cycle.
  - X_valid=1 with fields driven from the station register; zero-latency from eligibility.
  - The station clears at the clock edge.
  - pending[rd] is set at the edge when the dispatched op writes rd.
- Pending update order within one edge: clear wb_rd first, then set dispatched rds. A set wins on a same-register collision.
- Flush:
  - Both stations are emptied at the edge and X_valid is forced to 0 that cycle.
  - Same-cycle ib accept is suppressed.
  - pending is kept, so in-flight writebacks still clear it.
- Reset mid-operation: immediate return to the reset state; in-flight wb after reset is harmless (clears an already-0 bit).
- wb_rd=0 is ignored.

Decomposition:
- Shared package holds:
  - OPT_SIZE, FUNCT_SIZE, REG_SIZE;
  - opcode constants OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OPIMM;
  - an instruction-field struct, reused by i_buffer.
- One sub-module, sb_station: a single-entry holder with busy, the fields, and decoded uses_rs1/uses_rs2/writes_rd flags. It is instantiated twice.
- Hazard/age logic and the pending table live in the top module.

Test Plan:
- Reset:
  - Stimulus: assert rst=0 mid-run with both stations full.
  - Required: vacant_ALU=vacant_LS=1 and pending=0 immediately; no X_valid after release.
- Simple issue:
  - Stimulus: ADDI x5,x0,1 accepted, alu_ready=1.
  - Required: alu_valid the cycle after accept with rd=5; pending[5]=1 next; wb_rd=5 clears it.
- RAW stall:
  - Stimulus: ADD x6,x5,x5 accepted while pending[5]=1.
  - Required: no alu_valid until the wb_valid/wb_rd=5 cycle; dispatch happens in that same cycle (bypass).
- Cross-class ordering:
  - Stimulus: LW x7,0(x1) older in LS with ls_ready=0; ADD x8,x7,x2 younger in ALU.
  - Required: ALU holds.
  - Stimulus (variant): younger ADD x8,x3,x2.
  - Required: ALU dispatches first.
- WAR:
  - Stimulus: older SW x9,0(x2) stalled; younger ADDI x9,x0,3.
  - Required: ALU blocked until SW dispatches.
- Collision and flush:
  - Stimulus: wb_rd=5 plus dispatch of rd=5 in one cycle.
  - Required: pending[5] stays 1.
  - Stimulus: flush with both stations full.
  - Required: both vacant next cycle; pending unchanged.
